// File: rtl/raw10_pkg.sv
// Shared RAW10 definitions used by the encoder and decoder paths.
package raw10_pkg;

  localparam int unsigned PIXEL_BITS       = 10;
  localparam int unsigned LANE_BITS        = 16;
  localparam int unsigned PIXELS_PER_GROUP = 4;

  // Pairing FSM: S_A/S2 accept groups, the rest emit stored words.
  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    S4    = 3'd4,
    S_PAD = 3'd5
  } raw10_state_t;

  typedef logic [PIXELS_PER_GROUP-1:0][PIXEL_BITS-1:0] pix_group_t;

  // Upper eight bits of a pixel.
  function automatic logic [7:0] msb_byte(input logic [PIXEL_BITS-1:0] pixel);
    return pixel[PIXEL_BITS-1:2];
  endfunction

  // Two low bits of every pixel, first pixel in bits [1:0].
  function automatic logic [7:0] lsb_byte(input pix_group_t group);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < PIXELS_PER_GROUP; k++) begin
      b[2*k +: 2] = group[k][1:0];
    end
    return b;
  endfunction

  // Extract the 10-bit pixels from four 16-bit lanes; lane padding bits dropped.
  function automatic pix_group_t lanes_to_group(
    input logic [PIXELS_PER_GROUP*LANE_BITS-1:0] lanes
  );
    pix_group_t g;
    for (int unsigned k = 0; k < PIXELS_PER_GROUP; k++) begin
      g[k] = lanes[LANE_BITS*k +: PIXEL_BITS];
    end
    return g;
  endfunction

endpackage

// File: rtl/raw10_encoder.sv
// RAW10 packer: two 4-pixel groups become five 16-bit words on the lane.
module raw10_encoder
  import raw10_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH  = 64,
  parameter int unsigned OUT_DATA_WIDTH = 16
) (
  input  logic                      txbyteclkhs,
  input  logic                      reset,
  input  logic [IN_DATA_WIDTH-1:0]  in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [OUT_DATA_WIDTH-1:0] data_out,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready
);

  raw10_state_t state;
  pix_group_t   grp_a;
  pix_group_t   grp_b;
  pix_group_t   in_grp;
  logic         a_last;
  logic         b_last;
  logic         slot_free;
  logic         unused_lane_bits;

  assign in_grp = lanes_to_group(in_data);
  assign unused_lane_bits = ^{in_data[63:58], in_data[47:42],
                              in_data[31:26], in_data[15:10]};

  // Output slot and input handshake; only S_A and S2 take a new group.
  always_comb begin
    slot_free = ~out_valid | out_ready;
    in_ready  = ~reset & slot_free & ((state == S_A) | (state == S2));
  end

  // Pairing FSM and registered output word; advances only when the slot is free.
  always_ff @(posedge txbyteclkhs or posedge reset) begin
    if (reset) begin
      state     <= S_A;
      grp_a     <= '0;
      grp_b     <= '0;
      a_last    <= 1'b0;
      b_last    <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (slot_free) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        S_A: begin
          if (in_valid) begin
            data_out  <= {msb_byte(in_grp[0]), msb_byte(in_grp[1])};
            out_valid <= 1'b1;
            grp_a     <= in_grp;
            a_last    <= in_last;
            state     <= S1;
          end
        end
        S1: begin
          data_out  <= {msb_byte(grp_a[2]), msb_byte(grp_a[3])};
          out_valid <= 1'b1;
          state     <= a_last ? S_PAD : S2;
        end
        S_PAD: begin
          data_out  <= {lsb_byte(grp_a), 8'h00};
          out_valid <= 1'b1;
          out_last  <= 1'b1;
          state     <= S_A;
        end
        S2: begin
          if (in_valid) begin
            data_out  <= {lsb_byte(grp_a), msb_byte(in_grp[0])};
            out_valid <= 1'b1;
            grp_b     <= in_grp;
            b_last    <= in_last;
            state     <= S3;
          end
        end
        S3: begin
          data_out  <= {msb_byte(grp_b[1]), msb_byte(grp_b[2])};
          out_valid <= 1'b1;
          state     <= S4;
        end
        S4: begin
          data_out  <= {msb_byte(grp_b[3]), lsb_byte(grp_b)};
          out_valid <= 1'b1;
          out_last  <= b_last;
          state     <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_raw10_encoder.sv
// Self-checking bench for raw10_encoder against a behavioural RAW10 model.
module tb_raw10_encoder;

  logic        txbyteclkhs = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;

  raw10_encoder #(.IN_DATA_WIDTH(64), .OUT_DATA_WIDTH(16)) dut (
    .txbyteclkhs(txbyteclkhs),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  always #5 txbyteclkhs = ~txbyteclkhs;

  int checks = 0;
  int passed = 0;

  logic [63:0] src_data[$];
  bit          src_last[$];
  logic [16:0] got_q[$];
  int          got_cyc[$];
  logic [16:0] exp_q[$];
  int          stable_err;

  localparam logic [63:0] PIX_MASK = 64'h03FF_03FF_03FF_03FF;

  // ---------------- reference model ----------------
  function automatic int pix(input logic [63:0] g, input int k);
    return int'(g[16*k +: 10]);
  endfunction

  function automatic int msb(input logic [63:0] g, input int k);
    return pix(g, k) / 4;
  endfunction

  function automatic int lsb(input logic [63:0] g);
    int s = 0;
    int w = 1;
    for (int k = 0; k < 4; k++) begin
      s += (pix(g, k) % 4) * w;
      w *= 4;
    end
    return s;
  endfunction

  function automatic logic [63:0] mk(input int p1, input int p2, input int p3, input int p4);
    return {6'b0, 10'(p4), 6'b0, 10'(p3), 6'b0, 10'(p2), 6'b0, 10'(p1)};
  endfunction

  function automatic logic [63:0] rand_group();
    return mk($urandom_range(1023), $urandom_range(1023),
              $urandom_range(1023), $urandom_range(1023));
  endfunction

  function automatic void emit(input int hi, input int lo, input bit last);
    exp_q.push_back({last, 8'(hi), 8'(lo)});
  endfunction

  // Expected word stream: lines split into A/B pairs, odd A padded.
  function automatic void build_expected();
    int i = 0;
    logic [63:0] a;
    logic [63:0] b;
    exp_q.delete();
    while (i < src_data.size()) begin
      a = src_data[i];
      emit(msb(a, 0), msb(a, 1), 1'b0);
      emit(msb(a, 2), msb(a, 3), 1'b0);
      if (src_last[i]) begin
        emit(lsb(a), 0, 1'b1);
        i += 1;
      end else if (i + 1 < src_data.size()) begin
        b = src_data[i+1];
        emit(lsb(a), msb(b, 0), 1'b0);
        emit(msb(b, 1), msb(b, 2), 1'b0);
        emit(msb(b, 3), lsb(b), src_last[i+1]);
        i += 2;
      end else begin
        i += 1;
      end
    end
  endfunction

  // ---------------- stream driver ----------------
  task automatic run_stream(input int ready_pct, input int nexp, input int budget);
    int idx = 0;
    int n = 0;
    bit held_valid = 1'b0;
    logic [16:0] held = '0;
    got_q.delete();
    got_cyc.delete();
    stable_err = 0;
    while ((idx < src_data.size() || got_q.size() < nexp) && n < budget) begin
      in_valid  = (idx < src_data.size());
      in_data   = in_valid ? src_data[idx] : {$urandom, $urandom};
      in_last   = in_valid ? src_last[idx] : 1'b0;
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge txbyteclkhs);
      if (held_valid && (out_valid !== 1'b1 || {out_last, data_out} !== held))
        stable_err++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, data_out});
        got_cyc.push_back(n);
      end
      held_valid = out_valid && !out_ready;
      held = {out_last, data_out};
      @(posedge txbyteclkhs);
      #1;
      n++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else passed++;
    checks++; if (data_out !== 16'h0000) $display("FAIL reset_data_out got %h want 0000", data_out); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
    repeat (3) @(posedge txbyteclkhs);
    @(negedge txbyteclkhs) reset = 1'b0;
    @(posedge txbyteclkhs);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_reference();
    logic [16:0] want[5];
    want[0] = {1'b0, 16'hFF00}; want[1] = {1'b0, 16'h8055}; want[2] = {1'b0, 16'h4701};
    want[3] = {1'b0, 16'hFF00}; want[4] = {1'b1, 16'hAAE0};
    src_data.delete(); src_last.delete();
    src_data.push_back(mk('h3FF, 'h001, 'h200, 'h155)); src_last.push_back(1'b0);
    src_data.push_back(mk('h004, 'h3FC, 'h002, 'h2AB)); src_last.push_back(1'b1);
    run_stream(100, 5, 50);
    checks++; if (got_q.size() != 5) $display("FAIL ref_count got %0d want 5", got_q.size()); else passed++;
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== want[k]) $display("FAIL ref_word%0d got %h want %h", k, got_q[k], want[k]);
      else passed++;
    end
    if (got_cyc.size() == 5) begin
      checks++; if (got_cyc[0] != 1) $display("FAIL ref_latency got %0d want 1", got_cyc[0]); else passed++;
      checks++;
      if (got_cyc[4] - got_cyc[0] != 4) $display("FAIL ref_back_to_back got span %0d want 4", got_cyc[4] - got_cyc[0]);
      else passed++;
    end
  endtask

  task automatic test_odd_line();
    logic [16:0] want[3];
    want[0] = {1'b0, 16'hFF00}; want[1] = {1'b0, 16'h8055}; want[2] = {1'b1, 16'h4700};
    src_data.delete(); src_last.delete();
    src_data.push_back(mk('h3FF, 'h001, 'h200, 'h155)); src_last.push_back(1'b1);
    run_stream(100, 3, 50);
    checks++; if (got_q.size() != 3) $display("FAIL odd_count got %0d want 3", got_q.size()); else passed++;
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== want[k]) $display("FAIL odd_word%0d got %h want %h", k, got_q[k], want[k]);
      else passed++;
    end
    checks++; if (in_ready !== 1'b1) $display("FAIL odd_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_backpressure();
    src_data.delete(); src_last.delete();
    for (int i = 0; i < 64; i++) begin
      src_data.push_back(rand_group());
      src_last.push_back(($urandom_range(3) == 0) || (i == 63));
    end
    build_expected();
    run_stream(50, exp_q.size(), 3000);
    checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL bp_word%0d got %h want %h", k, got_q[k], exp_q[k]);
      else passed++;
    end
    checks++; if (stable_err != 0) $display("FAIL bp_hold_stable got %0d changes want 0", stable_err); else passed++;
  endtask

  task automatic test_loopback();
    logic [63:0] dec[$];
    logic [16:0] w0, w1, w2, w3, w4;
    int wi = 0;
    int la;
    int lb;
    src_data.delete(); src_last.delete();
    for (int i = 0; i < 16; i++) begin
      src_data.push_back(rand_group() | ({$urandom, $urandom} & ~PIX_MASK));
      src_last.push_back(($urandom_range(2) == 0) || (i == 15));
    end
    build_expected();
    run_stream(70, exp_q.size(), 1000);
    // Behavioural RAW10 decode of the captured word stream.
    while (wi + 2 < got_q.size()) begin
      w0 = got_q[wi]; w1 = got_q[wi+1]; w2 = got_q[wi+2];
      la = int'(w2[15:8]);
      dec.push_back(mk(int'(w0[15:8]) * 4 + la % 4, int'(w0[7:0]) * 4 + (la / 4) % 4,
                       int'(w1[15:8]) * 4 + (la / 16) % 4, int'(w1[7:0]) * 4 + la / 64));
      if (w2[16] || wi + 4 >= got_q.size()) begin
        wi += 3;
      end else begin
        w3 = got_q[wi+3]; w4 = got_q[wi+4];
        lb = int'(w4[7:0]);
        dec.push_back(mk(int'(w2[7:0]) * 4 + lb % 4, int'(w3[15:8]) * 4 + (lb / 4) % 4,
                         int'(w3[7:0]) * 4 + (lb / 16) % 4, int'(w4[15:8]) * 4 + lb / 64));
        wi += 5;
      end
    end
    checks++; if (dec.size() != 16) $display("FAIL loop_count got %0d want 16", dec.size()); else passed++;
    for (int k = 0; k < 16 && k < dec.size(); k++) begin
      checks++;
      if (dec[k] !== (src_data[k] & PIX_MASK))
        $display("FAIL loop_group%0d got %h want %h", k, dec[k], src_data[k] & PIX_MASK);
      else passed++;
    end
  endtask

  task automatic test_ignored_bits();
    logic [16:0] clean_q[$];
    src_data.delete(); src_last.delete();
    for (int i = 0; i < 8; i++) begin
      src_data.push_back(rand_group());
      src_last.push_back(i == 7);
    end
    build_expected();
    run_stream(100, exp_q.size(), 200);
    clean_q = got_q;
    checks++;
    if (clean_q.size() != exp_q.size()) $display("FAIL ign_clean_count got %0d want %0d", clean_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < 8; i++) src_data[i] = src_data[i] | ~PIX_MASK;
    run_stream(100, exp_q.size(), 200);
    checks++;
    if (got_q.size() != clean_q.size()) $display("FAIL ign_count got %0d want %0d", got_q.size(), clean_q.size());
    else passed++;
    for (int k = 0; k < clean_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL ign_word%0d got %h want %h", k, got_q[k], exp_q[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_pair();
    logic [63:0] ga;
    logic [63:0] gb;
    logic [63:0] gc;
    logic [15:0] w;
    ga = rand_group(); gb = rand_group(); gc = rand_group();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = ga; in_last = 1'b0;
    @(posedge txbyteclkhs); #1;
    in_valid = 1'b0;
    @(posedge txbyteclkhs); #1;
    in_valid = 1'b1; in_data = gb;
    @(posedge txbyteclkhs); #1;
    in_valid = 1'b0;
    w = 16'(lsb(ga) * 256 + msb(gb, 0));
    checks++;
    if (out_valid !== 1'b1 || data_out !== w) $display("FAIL midpair_pre got %b/%h want 1/%h", out_valid, data_out, w);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midpair_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (data_out !== 16'h0000) $display("FAIL midpair_data_out got %h want 0000", data_out); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL midpair_in_ready got %b want 0", in_ready); else passed++;
    @(negedge txbyteclkhs) reset = 1'b0;
    @(posedge txbyteclkhs); #1;
    src_data.delete(); src_last.delete();
    src_data.push_back(gc); src_last.push_back(1'b1);
    build_expected();
    run_stream(100, 3, 50);
    checks++; if (got_q.size() != 3) $display("FAIL midpair_count got %0d want 3", got_q.size()); else passed++;
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL midpair_word%0d got %h want %h", k, got_q[k], exp_q[k]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_odd_line();
    test_backpressure();
    test_loopback();
    test_ignored_bits();
    test_reset_mid_pair();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/raw10_encoder.md
# raw10_encoder

Packs 10-bit pixels into the CSI-2 RAW10 byte stream on a 16-bit (two-byte-per-cycle) lane interface. It is the transmit-side counterpart of the RAW10 decode path and is used by the pattern generator / loopback path ahead of the packet framer. Every two accepted 4-pixel groups become five 16-bit words. The byte order is exactly what the RAW10 decoder expects.

## Interface
- IN_DATA_WIDTH, 64, input group width: 4 pixel lanes of 16 bits. Only 64 is legal.
- OUT_DATA_WIDTH, 16, output word width: byte1 in [15:8], byte2 in [7:0]. Only 16 is legal.

- txbyteclkhs  input  1  byte clock; all logic on its rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  64  pixel k (k=0..3) in [16k+9:16k]; bits [16k+15:16k+10] are ignored
- in_valid  input  1  in_data/in_last valid
- in_last  input  1  this group is the last of the line
- in_ready  output  1  encoder accepts the group this cycle
- data_out  output  16  packed RAW10 word
- out_valid  output  1  data_out valid
- out_last  output  1  final word of the line
- out_ready  input  1  downstream accepts data_out

## Operation
- Notation:
  - Group A holds pixels P1..P4; group B holds P5..P8.
  - MSB(p) = p[9:2].
  - LSB byte of a group = {P4[1:0], P3[1:0], P2[1:0], P1[1:0]}, with the first pixel in bits [1:0].
- Slot free = ~out_valid | out_ready. Output registers load only when the slot is free.
- States, with the word emitted on each transition:
  - S_A: in_ready = slot free. On accept: emit {MSB(P1), MSB(P2)}, store A and in_last, go to S1.
  - S1: on slot free: emit {MSB(P3), MSB(P4)}.
    - If the stored A is last: go to S_PAD.
    - Otherwise: go to S2.
  - S_PAD: on slot free: emit {LSB(A), 8'h00} with out_last=1, go to S_A.
  - S2: in_ready = slot free. On accept B: emit {LSB(A), MSB(P5)}, store B and in_last, go to S3.
  - S3: on slot free: emit {MSB(P6), MSB(P7)}, go to S4.
  - S4: on slot free: emit {MSB(P8), LSB(B)}, with out_last = stored B last, go to S_A.
- If in_last arrives with group B, that is accepted normally; it only tags the S4 word.
- When the slot is free and nothing is loaded, out_valid drops to 0 and data_out holds its last value.
- in_ready is 0 in S1, S_PAD, S3 and S4. A group presented in those states waits, and the upstream source holds it.
- Reset (asynchronous, any time, including mid-pair):
  - State goes to S_A.
  - out_valid=0, out_last=0, data_out=16'h0000, in_ready=0 while reset is asserted.
  - Stored groups are discarded; no partial pair is flushed.

## Timing
- Latency: the first word of a group appears one cycle after acceptance (registered output).
- Throughput: with out_ready held at 1 and input always valid, one word per cycle, i.e. 5 words per 8 pixels. in_ready is high every 2nd, then every 3rd cycle.
- out_valid/data_out/out_last hold stable while out_valid & ~out_ready.
- Combinational paths:
  - in_ready depends combinationally on state, out_valid and out_ready.
  - There is no combinational path from in_data or in_valid to any output.
- Simultaneous accept and drain in the same cycle is allowed, so there is no bubble.

## Structure
- Shared package raw10_pkg, used by both the encoder and the decoder:
  - state enum (S_A, S1, S2, S3, S4, S_PAD)
  - PIXEL_BITS=10, LANE_BITS=16, PIXELS_PER_GROUP=4
  - functions msb_byte(pixel) and lsb_byte(group)
- Single module; no sub-module is needed.

## Test plan
- Reference pair, out_ready=1:
  - Stimulus: A = {P1=0x3FF, P2=0x001, P3=0x200, P4=0x155}, then B = {P5=0x004, P6=0x3FC, P7=0x002, P8=0x2AB}, in_last on B.
  - Response: words 0xFF00, 0x8055, 0x4701, 0xFF00, 0xAAE0 on consecutive cycles; out_last only on 0xAAE0.
- Odd line:
  - Stimulus: A from the reference pair alone, with in_last=1.
  - Response: 0xFF00, 0x8055, 0x4700 with out_last=1; in_ready high again in S_A.
- Backpressure:
  - Stimulus: random out_ready (50%) over 64 random groups.
  - Response: the word sequence matches the golden model; data_out is never changed while out_valid & ~out_ready.
- Loopback:
  - Stimulus: 16 random groups fed through the encoder into raw10_decoder.
  - Response: decoder data_out equals the original groups, with upper 6 bits zero.
- Ignored bits:
  - Stimulus: in_data lanes with bits [15:10] set to 1.
  - Response: output identical to the same data with those bits 0.
- Reset mid-pair:
  - Stimulus: assert reset asynchronously (off the clock edge) in S3.
  - Response: out_valid=0 and data_out=0x0000 immediately. After release, the next group produces MSB words starting from S_A.
